instruction_fetch_unit: RTL and testbench

//  Fetch stage directly downstream of instruction_pointer: reads ip_out, issues one

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/instruction_fetch_unit.sv | 100 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: default widths, FSM state encoding and
// the {pc, instr} record carried through the prefetch queue.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 16;
  localparam int FETCH_INSTR_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue for fetch_entry_t records: push/pop/clear with occupancy count.
// Clear wins over push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               clear,
  output fetch_entry_t       head_data,
  output logic [CNT_W-1:0]   count,
  output logic               empty
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_entry_t     mem_q [DEPTH];
  logic             full_s, push_ok_s, pop_ok_s;

  assign full_s    = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == CNT_W'(0));
  assign push_ok_s = push && !full_s;
  assign pop_ok_s  = pop && !empty;

  // Next-state pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = PTR_W'(0);
      rd_ptr_d = PTR_W'(0);
      count_d  = CNT_W'(0);
    end else begin
      if (push_ok_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (pop_ok_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, count and storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok_s && !clear) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage between instruction_pointer, instruction memory and decode.
// Optional memory-stall counter enabled by defining FETCH_STATS_EN.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = FETCH_ADDR_W,
  parameter int INSTR_W    = FETCH_INSTR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  ip,
  output logic               inc_ip,
  output logic               load_ip,
  output logic [ADDR_W-1:0]  ip_in,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic [15:0]        stall_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state_q;
  logic             mem_req_s, beat_s, pop_s, empty_s;
  logic [CNT_W-1:0] count_s;
  fetch_entry_t     push_entry_s, head_entry_s;

  // A redirect suppresses the request, so no beat (and no push) can coincide with it
  assign mem_req_s = (state_q == FETCH) && (count_s < CNT_W'(FIFO_DEPTH)) && !redirect;
  assign beat_s    = mem_req_s && mem_ready;
  assign pop_s     = !empty_s && inst_ready;

  assign push_entry_s.pc    = ip;
  assign push_entry_s.instr = mem_rdata;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (beat_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .clear     (redirect),
    .head_data (head_entry_s),
    .count     (count_s),
    .empty     (empty_s)
  );

  // Fetch FSM; a pending request keeps FETCH alive until its beat completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    state_q <= fetch_en ? FETCH : IDLE;
        FETCH:   state_q <= (fetch_en || (mem_req_s && !mem_ready)) ? FETCH : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req    = mem_req_s;
  assign mem_addr   = ip;
  assign inc_ip     = beat_s;
  assign load_ip    = redirect;
  assign ip_in      = redirect ? redirect_pc : {ADDR_W{1'b0}};
  assign inst_valid = !empty_s;
  assign inst_data  = head_entry_s.instr;
  assign inst_pc    = head_entry_s.pc;

`ifdef FETCH_STATS_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles spent waiting on memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else if (mem_req_s && !mem_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table,
// hand-written corner sequences and a randomized run against a queue model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, redirect, mem_ready, inst_ready;
  logic [15:0] ip, redirect_pc, mem_rdata;
  logic        inc_ip, load_ip, mem_req, inst_valid;
  logic [15:0] ip_in, mem_addr, inst_data, inst_pc, stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .ip          (ip),
    .inc_ip      (inc_ip),
    .load_ip     (load_ip),
    .ip_in       (ip_in),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .stall_cnt   (stall_cnt)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'(a + 16'h00A0);
  endfunction

  function automatic logic [15:0] exp_stall(input int n);
`ifdef FETCH_STATS_EN
    return 16'(n);
`else
    return 16'h0000 & 16'(n);
`endif
  endfunction

  // instruction_pointer stand-in and combinational instruction memory
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ip <= 16'h0000;
    else if (load_ip) ip <= ip_in;
    else if (inc_ip)  ip <= ip + 16'h0001;
  end

  always_comb mem_rdata = mem_word(mem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fe, input logic mr, input logic ir,
                       input logic rd, input logic [15:0] rpc);
    fetch_en    = fe;
    mem_ready   = mr;
    inst_ready  = ir;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},   32'(mem_req),    32'h0);
    chk({tag, "_inc"},   32'(inc_ip),     32'h0);
    chk({tag, "_load"},  32'(load_ip),    32'h0);
    chk({tag, "_valid"}, 32'(inst_valid), 32'h0);
    chk({tag, "_ipin"},  32'(ip_in),      32'h0);
    chk({tag, "_stall"}, 32'(stall_cnt),  32'h0);
  endtask

  typedef struct {
    logic        fe, mr, ir, rd;
    logic [15:0] rpc;
    logic        req;
    logic [15:0] addr;
    logic        inc, load;
    logic [15:0] ipin;
    logic        valid;
    logic [15:0] ipc, idata;
  } vec_t;

  function automatic vec_t mk(input logic fe, mr, ir, rd, input logic [15:0] rpc,
                              input logic req, input logic [15:0] addr,
                              input logic inc, load, input logic [15:0] ipin,
                              input logic valid, input logic [15:0] ipc, idata);
    vec_t v;
    v.fe = fe; v.mr = mr; v.ir = ir; v.rd = rd; v.rpc = rpc;
    v.req = req; v.addr = addr; v.inc = inc; v.load = load; v.ipin = ipin;
    v.valid = valid; v.ipc = ipc; v.idata = idata;
    return v;
  endfunction

  vec_t tbl [18];

  // queue model state for the random run
  bit          m_fetch;
  logic [31:0] m_q[$];
  logic [15:0] m_ptr;
  int          m_stall;

  initial begin
    // Directed stream: steady fetch, queue fill/drain, redirect with 2 queued, fetch_en drop
    tbl[0]  = mk(1,1,1,0,16'h0000, 0,16'h0000,0,0,16'h0000, 0,16'h0000,16'h0000);
    tbl[1]  = mk(1,1,1,0,16'h0000, 1,16'h0000,1,0,16'h0000, 0,16'h0000,16'h0000);
    tbl[2]  = mk(1,1,1,0,16'h0000, 1,16'h0001,1,0,16'h0000, 1,16'h0000,16'h00A0);
    tbl[3]  = mk(1,1,1,0,16'h0000, 1,16'h0002,1,0,16'h0000, 1,16'h0001,16'h00A1);
    tbl[4]  = mk(1,1,1,0,16'h0000, 1,16'h0003,1,0,16'h0000, 1,16'h0002,16'h00A2);
    tbl[5]  = mk(1,1,0,0,16'h0000, 1,16'h0004,1,0,16'h0000, 1,16'h0003,16'h00A3);
    tbl[6]  = mk(1,1,0,0,16'h0000, 0,16'h0005,0,0,16'h0000, 1,16'h0003,16'h00A3);
    tbl[7]  = mk(1,1,0,0,16'h0000, 0,16'h0005,0,0,16'h0000, 1,16'h0003,16'h00A3);
    tbl[8]  = mk(1,1,1,0,16'h0000, 0,16'h0005,0,0,16'h0000, 1,16'h0003,16'h00A3);
    tbl[9]  = mk(1,0,0,0,16'h0000, 1,16'h0005,0,0,16'h0000, 1,16'h0004,16'h00A4);
    tbl[10] = mk(1,1,0,0,16'h0000, 1,16'h0005,1,0,16'h0000, 1,16'h0004,16'h00A4);
    tbl[11] = mk(1,1,0,1,16'h0100, 0,16'h0006,0,1,16'h0100, 1,16'h0004,16'h00A4);
    tbl[12] = mk(1,1,1,0,16'h0000, 1,16'h0100,1,0,16'h0000, 0,16'h0000,16'h0000);
    tbl[13] = mk(0,0,0,0,16'h0000, 1,16'h0101,0,0,16'h0000, 1,16'h0100,16'h01A0);
    tbl[14] = mk(0,1,0,0,16'h0000, 1,16'h0101,1,0,16'h0000, 1,16'h0100,16'h01A0);
    tbl[15] = mk(0,1,1,0,16'h0000, 0,16'h0102,0,0,16'h0000, 1,16'h0100,16'h01A0);
    tbl[16] = mk(0,1,1,0,16'h0000, 0,16'h0102,0,0,16'h0000, 1,16'h0101,16'h01A1);
    tbl[17] = mk(0,1,1,0,16'h0000, 0,16'h0102,0,0,16'h0000, 0,16'h0000,16'h0000);

    // Reset state, then reset in the middle of a pending request
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    next_cycle();
    @(negedge clk);
    chk("t1_req_pending", 32'(mem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_zero("t1_midrst");
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("t1_req_after", 32'(mem_req), 32'h1);
    chk("t1_addr_after", 32'(mem_addr), 32'h0);
    chk("t1_valid_after", 32'(inst_valid), 32'h0);

    // Vector table
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].fe, tbl[i].mr, tbl[i].ir, tbl[i].rd, tbl[i].rpc);
      @(negedge clk);
      chk($sformatf("row%0d_req", i),   32'(mem_req),    32'(tbl[i].req));
      chk($sformatf("row%0d_addr", i),  32'(mem_addr),   32'(tbl[i].addr));
      chk($sformatf("row%0d_inc", i),   32'(inc_ip),     32'(tbl[i].inc));
      chk($sformatf("row%0d_load", i),  32'(load_ip),    32'(tbl[i].load));
      chk($sformatf("row%0d_ipin", i),  32'(ip_in),      32'(tbl[i].ipin));
      chk($sformatf("row%0d_valid", i), 32'(inst_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("row%0d_pc", i),   32'(inst_pc),   32'(tbl[i].ipc));
        chk($sformatf("row%0d_data", i), 32'(inst_data), 32'(tbl[i].idata));
      end
      next_cycle();
    end

    // Three-cycle memory stall followed by a single beat
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    chk("t4_idle_req", 32'(mem_req), 32'h0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t4_stall%0d_req", i),  32'(mem_req),  32'h1);
      chk($sformatf("t4_stall%0d_addr", i), 32'(mem_addr), 32'h0);
      chk($sformatf("t4_stall%0d_inc", i),  32'(inc_ip),   32'h0);
      next_cycle();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("t4_beat_inc", 32'(inc_ip), 32'h1);
    chk("t4_stall_cnt", 32'(stall_cnt), 32'(exp_stall(3)));
    next_cycle();

    // Redirect to FFFF, then fetch across the wrap
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    @(negedge clk);
    chk("t6_head_pc", 32'(inst_pc), 32'h0);
    chk("t6_head_data", 32'(inst_data), 32'h00A0);
    chk("t6_load", 32'(load_ip), 32'h1);
    chk("t6_ipin", 32'(ip_in), 32'hFFFF);
    chk("t6_req_blocked", 32'(mem_req), 32'h0);
    chk("t6_inc_blocked", 32'(inc_ip), 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    chk("t6_flushed", 32'(inst_valid), 32'h0);
    chk("t6_addr_ffff", 32'(mem_addr), 32'hFFFF);
    chk("t6_inc", 32'(inc_ip), 32'h1);
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("t6_addr_wrap", 32'(mem_addr), 32'h0);
    chk("t6_pc_ffff", 32'(inst_pc), 32'hFFFF);
    chk("t6_data_ffff", 32'(inst_data), 32'(mem_word(16'hFFFF)));
    next_cycle();

    // Randomized run against the queue model
    do_reset();
    m_fetch = 1'b0;
    m_q.delete();
    m_ptr = 16'h0000;
    m_stall = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic        e_req;
      logic [15:0] rpc;
      rpc = 16'($urandom);
      drive(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 24) == 0), rpc);
      @(negedge clk);
      e_req = m_fetch && (m_q.size() < 2) && !redirect;
      chk("rnd_req",   32'(mem_req),    32'(e_req));
      chk("rnd_addr",  32'(mem_addr),   32'(m_ptr));
      chk("rnd_inc",   32'(inc_ip),     32'(e_req && mem_ready));
      chk("rnd_load",  32'(load_ip),    32'(redirect));
      chk("rnd_ipin",  32'(ip_in),      redirect ? 32'(redirect_pc) : 32'h0);
      chk("rnd_valid", 32'(inst_valid), 32'(m_q.size() != 0));
      chk("rnd_stall", 32'(stall_cnt),  32'(exp_stall(m_stall)));
      if (m_q.size() != 0) chk("rnd_head", {inst_pc, inst_data}, m_q[0]);

      if ((m_q.size() != 0) && inst_ready) void'(m_q.pop_front());
      if (redirect) begin
        m_q.delete();
        m_ptr = redirect_pc;
      end else if (e_req && mem_ready) begin
        m_q.push_back({m_ptr, mem_word(m_ptr)});
        m_ptr = m_ptr + 16'h0001;
      end
      if (e_req && !mem_ready && (m_stall < 65535)) m_stall++;
      m_fetch = m_fetch ? (fetch_en || (e_req && !mem_ready)) : fetch_en;
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
